// File: rtl/display_reader_if.sv
// Read port between the display reader and the display side of the board double buffer.
interface display_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr_r_out;
    logic [DATA_W-1:0] data_r_in;

    modport master (output addr_r_out, input data_r_in);
    modport slave  (input addr_r_out, output data_r_in);
endinterface

// File: rtl/display_reader.sv
// Fetches one board row per cell line into a double line buffer and renders the
// board, cell borders and cursor overlay as RGB444 pixels.
module display_reader #(
    parameter int BOARD_SIZE     = 64,
    parameter int WORD_SIZE      = 16,
    parameter int CELL_SHIFT     = 3,
    parameter int READ_LATENCY   = 2,
    parameter int H_ACTIVE       = 1024,
    parameter int H_TOTAL        = 1344,
    parameter int V_TOTAL        = 806,
    parameter int LOG_BOARD_SIZE = $clog2(BOARD_SIZE),
    parameter int LOG_MAX_ADDR   = $clog2(BOARD_SIZE * (BOARD_SIZE / WORD_SIZE))
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    display_reader_if.master          mem,
    output logic [11:0]               pixel_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      blank_out,
    output logic                      underrun_out
);
    localparam int WORDS_PER_ROW = BOARD_SIZE / WORD_SIZE;
    localparam int LOG_WORDS     = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [LOG_WORDS-1:0] LAST_WORD = LOG_WORDS'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    state_t                    state_r, next_state_s;
    logic [10:0]               next_line_s, next_row_s;
    logic                      trigger_s, accept_s, issue_s, swap_s, underrun_s;
    logic                      swap_point_s, cap_s;
    logic [LOG_BOARD_SIZE-1:0] row_r, target_row_s;
    logic [LOG_WORDS-1:0]      word_cnt_r, issued_idx_r, cap_idx_s;
    logic                      issued_r;
    logic [READ_LATENCY-1:0]   vld_pipe_r;
    logic [LOG_WORDS-1:0]      idx_pipe_r [READ_LATENCY];
    logic [LOG_MAX_ADDR-1:0]   addr_r, addr_s;
    logic [BOARD_SIZE-1:0]     line_buf_r [2];
    logic                      sel_r, back_sel_s, pending_r;
    logic [BOARD_SIZE-1:0]     front_s;
    logic [10:0]               cx_s;
    logic [9:0]                cy_s;
    logic                      inside_s, border_s, cursor_s, live_s;
    logic [LOG_BOARD_SIZE-1:0] cell_idx_s;
    logic [11:0]               pixel_s, pixel_r;
    logic                      hsync_r, vsync_r, blank_r, underrun_r;

    // The last line of the frame prefetches row 0; otherwise the last line of a cell row prefetches the next row.
    assign next_line_s  = {1'b0, vcount_in} + 11'd1;
    assign next_row_s   = next_line_s >> CELL_SHIFT;
    assign trigger_s    = (hcount_in == 11'(H_ACTIVE)) &&
                          ((vcount_in == 10'(V_TOTAL - 1)) ||
                           ((&vcount_in[CELL_SHIFT-1:0]) && (next_row_s < 11'(BOARD_SIZE))));
    assign target_row_s = (vcount_in == 10'(V_TOTAL - 1)) ? {LOG_BOARD_SIZE{1'b0}}
                                                          : next_row_s[LOG_BOARD_SIZE-1:0];
    assign swap_point_s = pending_r && (hcount_in == 11'(H_TOTAL - 1));
    assign addr_s       = LOG_MAX_ADDR'(row_r) * LOG_MAX_ADDR'(WORDS_PER_ROW) + LOG_MAX_ADDR'(word_cnt_r);
    assign cap_s        = vld_pipe_r[READ_LATENCY-1];
    assign cap_idx_s    = idx_pipe_r[READ_LATENCY-1];
    assign back_sel_s   = ~sel_r;

    // Fetch FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fetch FSM next state and control strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        swap_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (trigger_s) begin
                    accept_s     = 1'b1;
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                issue_s = 1'b1;
                if (word_cnt_r == LAST_WORD) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (cap_s && (cap_idx_s == LAST_WORD)) begin
                    next_state_s = READY;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            READY: begin
                if (swap_point_s) begin
                    swap_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = READY;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (swap_point_s && (state_r != READY)) begin
            underrun_s = 1'b1;
        end else begin
            underrun_s = 1'b0;
        end
    end

    // Address issue and read tagging; the first tag stage lines up with addr_r_out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row_r        <= {LOG_BOARD_SIZE{1'b0}};
            word_cnt_r   <= {LOG_WORDS{1'b0}};
            addr_r       <= {LOG_MAX_ADDR{1'b0}};
            issued_r     <= 1'b0;
            issued_idx_r <= {LOG_WORDS{1'b0}};
            vld_pipe_r   <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                idx_pipe_r[i] <= {LOG_WORDS{1'b0}};
            end
        end else begin
            if (accept_s) begin
                row_r      <= target_row_s;
                word_cnt_r <= {LOG_WORDS{1'b0}};
            end else if (issue_s) begin
                addr_r     <= addr_s;
                word_cnt_r <= word_cnt_r + LOG_WORDS'(1);
            end
            issued_r      <= issue_s;
            issued_idx_r  <= word_cnt_r;
            vld_pipe_r[0] <= issued_r;
            idx_pipe_r[0] <= issued_idx_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                idx_pipe_r[i] <= idx_pipe_r[i-1];
            end
        end
    end

    // Line buffers, front select and pending-swap flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            line_buf_r[0] <= {BOARD_SIZE{1'b0}};
            line_buf_r[1] <= {BOARD_SIZE{1'b0}};
            sel_r         <= 1'b0;
            pending_r     <= 1'b0;
        end else begin
            if (cap_s) begin
                line_buf_r[back_sel_s][BOARD_SIZE-1-WORD_SIZE*int'(cap_idx_s) -: WORD_SIZE] <= mem.data_r_in;
            end
            if (swap_s) begin
                sel_r <= ~sel_r;
            end
            if (accept_s) begin
                pending_r <= 1'b1;
            end else if (swap_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign front_s    = line_buf_r[sel_r];
    assign cx_s       = hcount_in >> CELL_SHIFT;
    assign cy_s       = vcount_in >> CELL_SHIFT;
    assign inside_s   = (cx_s < 11'(BOARD_SIZE)) && (cy_s < 10'(BOARD_SIZE));
    assign border_s   = (~|hcount_in[CELL_SHIFT-1:0]) || (~|vcount_in[CELL_SHIFT-1:0]);
    assign cursor_s   = (cx_s == 11'(cursor_x_in)) && (cy_s == 10'(cursor_y_in));
    assign cell_idx_s = LOG_BOARD_SIZE'(BOARD_SIZE - 1) - cx_s[LOG_BOARD_SIZE-1:0];
    assign live_s     = front_s[cell_idx_s];

    // Pixel colour by priority: blanking, off-board, cursor frame, live cell, grid.
    always_comb begin
        pixel_s = 12'h000;
        if (blank_in) begin
            pixel_s = 12'h000;
        end else if (!inside_s) begin
            pixel_s = 12'h000;
        end else if (cursor_s && border_s) begin
            pixel_s = 12'hF00;
        end else if (live_s) begin
            pixel_s = 12'hFFF;
        end else if (border_s) begin
            pixel_s = 12'h444;
        end else begin
            pixel_s = 12'h000;
        end
    end

    // Registered pixel, delayed timing and underrun pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_r    <= 12'h000;
            hsync_r    <= 1'b0;
            vsync_r    <= 1'b0;
            blank_r    <= 1'b1;
            underrun_r <= 1'b0;
        end else begin
            pixel_r    <= pixel_s;
            hsync_r    <= hsync_in;
            vsync_r    <= vsync_in;
            blank_r    <= blank_in;
            underrun_r <= underrun_s;
        end
    end

    assign mem.addr_r_out = addr_r;
    assign pixel_out      = pixel_r;
    assign hsync_out      = hsync_r;
    assign vsync_out      = vsync_r;
    assign blank_out      = blank_r;
    assign underrun_out   = underrun_r;
endmodule

// File: tb/tb_display_reader.sv
// Scoreboard bench for display_reader: stimulus schedules expected outputs by cycle,
// a negedge monitor compares them against the DUT.
module tb_display_reader;
    localparam int READ_LATENCY = 2;
    localparam int K_PIX = 0, K_ADDR = 1, K_UND = 2, K_TIM = 3;

    typedef struct {
        int          due;
        int          kind;
        logic [11:0] exp;
        string       name;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic [5:0]  cursor_x_in, cursor_y_in;
    logic [11:0] pixel_out;
    logic        hsync_out, vsync_out, blank_out, underrun_out;

    display_reader_if #(.ADDR_W(8), .DATA_W(16)) mem_if ();

    display_reader dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .blank_in     (blank_in),
        .cursor_x_in  (cursor_x_in),
        .cursor_y_in  (cursor_y_in),
        .mem          (mem_if),
        .pixel_out    (pixel_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .blank_out    (blank_out),
        .underrun_out (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   und_cnt = 0;
    exp_t sb_q[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Board memory with READ_LATENCY cycles from address to data.
    logic [15:0] mem [256];
    logic [15:0] rd_pipe [READ_LATENCY];
    always @(posedge clk_in) begin
        rd_pipe[0] <= mem[mem_if.addr_r_out];
        for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_if.data_r_in = rd_pipe[READ_LATENCY-1];

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge clk_in) begin
        logic [11:0] act;
        if (underrun_out === 1'b1) und_cnt++;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                case (sb_q[i].kind)
                    K_PIX:   act = pixel_out;
                    K_ADDR:  act = {4'h0, mem_if.addr_r_out};
                    K_UND:   act = {11'h000, underrun_out};
                    K_TIM:   act = {9'h000, hsync_out, vsync_out, blank_out};
                    default: act = 12'hxxx;
                endcase
                n_checks++;
                if (act !== sb_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: actual %h, expected %h (cycle %0d)", sb_q[i].name, act, sb_q[i].exp, cyc);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int due, input int kind, input logic [11:0] e, input string nm);
        exp_t x;
        x.due = due; x.kind = kind; x.exp = e; x.name = nm;
        sb_q.push_back(x);
    endtask

    task automatic drive(input int h, input int v, input logic bl = 1'b0);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        blank_in  = bl;
        @(posedge clk_in);
        #1;
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] e, input string nm, input logic bl = 1'b0);
        expect_at(cyc + 1, K_PIX, e, nm);
        drive(h, v, bl);
    endtask

    task automatic reset_checks();
        expect_at(cyc, K_ADDR, 12'h000, "rst_addr");
        expect_at(cyc, K_PIX,  12'h000, "rst_pixel");
        expect_at(cyc, K_TIM,  12'h001, "rst_timing");
        expect_at(cyc, K_UND,  12'h000, "rst_underrun");
    endtask

    // Trigger a row fetch, check the four addresses, then swap at the end of the line.
    task automatic fetch(input int v, input int row);
        int n0;
        n0 = cyc;
        for (int k = 0; k < 4; k++) expect_at(n0 + 2 + k, K_ADDR, 12'(row * 4 + k), "fetch_addr");
        drive(1024, v);
        for (int k = 0; k < 10; k++) drive(1025 + k, v);
        expect_at(cyc + 1, K_UND, 12'h000, "swap_no_underrun");
        drive(1343, v);
        drive(1100, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        rst_n_in = 1'b0; hcount_in = 11'd0; vcount_in = 10'd0;
        hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b0;
        cursor_x_in = 6'd63; cursor_y_in = 6'd63;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (2) @(posedge clk_in);
        #1;
        reset_checks();
        drive(1100, 300);
        rst_n_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        drive(1100, 300);

        // Row 0: leftmost and rightmost cells live.
        mem[0] = 16'h8000; mem[3] = 16'h0001;
        fetch(805, 0);
        pix(17, 0, 12'h444, "row0_dead_border");
        pix(0, 0, 12'hFFF, "row0_live_over_border");
        pix(5, 1, 12'hFFF, "row0_cell0_interior");
        pix(509, 1, 12'hFFF, "row0_cell63_interior");
        pix(9, 1, 12'h000, "row0_cell1_dead");
        pix(17, 1, 12'h000, "row0_cell2_dead");
        hsync_in = 1'b1;
        expect_at(cyc + 1, K_TIM, 12'h004, "hsync_delay");
        drive(200, 1);
        hsync_in = 1'b0; vsync_in = 1'b1;
        expect_at(cyc + 1, K_TIM, 12'h003, "vsync_blank_delay");
        pix(5, 1, 12'h000, "blank_forces_black", 1'b1);
        vsync_in = 1'b0;

        // Row 5: cells 1 and 39 live.
        mem[20] = 16'h4000; mem[22] = 16'h0100;
        fetch(39, 5);
        pix(13, 40, 12'hFFF, "row5_cell1");
        pix(5, 40, 12'h444, "row5_cell0_border");
        pix(317, 40, 12'hFFF, "row5_cell39");
        pix(318, 41, 12'hFFF, "row5_cell39_interior");
        pix(21, 41, 12'h000, "row5_cell2_dead");

        // Cursor overlay on an all-dead row 0.
        mem[0] = 16'h0000; mem[3] = 16'h0000;
        cursor_x_in = 6'd2; cursor_y_in = 6'd0;
        fetch(805, 0);
        for (int h = 16; h < 24; h++) pix(h, 0, 12'hF00, "cursor_top_edge");
        pix(8, 0, 12'h444, "grid_border");
        pix(520, 0, 12'h000, "outside_board");
        pix(16, 0, 12'h000, "blank_over_cursor", 1'b1);
        pix(18, 1, 12'h000, "cursor_interior");
        pix(16, 1, 12'hF00, "cursor_left_edge");

        // Underrun: swap point reached while the row 1 fetch is still draining.
        mem[4] = 16'hFFFF;
        n0 = cyc;
        for (int k = 0; k < 4; k++) expect_at(n0 + 2 + k, K_ADDR, 12'(4 + k), "row1_addr");
        drive(1024, 7);
        for (int k = 0; k < 4; k++) drive(1025 + k, 7);
        expect_at(cyc + 1, K_UND, 12'h001, "underrun_pulse");
        drive(1343, 7);
        expect_at(cyc + 1, K_UND, 12'h000, "underrun_one_cycle");
        for (int k = 0; k < 6; k++) drive(1100 + k, 7);
        pix(3, 7, 12'h000, "no_swap_on_underrun");
        expect_at(cyc + 1, K_UND, 12'h000, "late_swap_no_pulse");
        drive(1343, 8);
        pix(3, 9, 12'hFFF, "late_swap_row1_live");
        pix(130, 9, 12'h000, "late_swap_row1_dead");

        // Reset during ISSUE, then a clean fetch with new memory contents.
        for (int i = 20; i < 24; i++) mem[i] = 16'hFFFF;
        n0 = cyc;
        expect_at(n0 + 2, K_ADDR, 12'd20, "addr_before_reset");
        drive(1024, 39);
        drive(1025, 39);
        drive(1026, 39);
        hsync_in = 1'b1;
        rst_n_in = 1'b0;
        reset_checks();
        repeat (3) drive(1027, 39);
        rst_n_in = 1'b1; hsync_in = 1'b0;
        mem[20] = 16'h0000; mem[21] = 16'h0000; mem[22] = 16'h0000; mem[23] = 16'h0001;
        drive(1100, 39);
        fetch(39, 5);
        pix(9, 41, 12'h000, "post_reset_cell1");
        pix(509, 41, 12'hFFF, "post_reset_cell63");
        pix(3, 41, 12'h000, "post_reset_cell0");

        // Row beyond the board: no fetch, address holds.
        expect_at(cyc + 4, K_ADDR, 12'd23, "no_fetch_beyond_board");
        drive(1024, 519);
        repeat (6) drive(1100, 519);

        repeat (4) drive(1100, 300);
        foreach (sb_q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation never reached (due cycle %0d)", sb_q[i].name, sb_q[i].due);
        end
        n_checks++;
        if (und_cnt != 1) begin
            n_fail++;
            $display("FAIL underrun_count: actual %0d, expected 1", und_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
